// File: rtl/stream_pkg.sv
// stream_pkg: shared types and helpers for the stream packing path.
//   state_t   : packer FSM states (IDLE waits for a frame length, RUN drains words)
//   clog2     : ceiling log2, minimum 1, for sizing lane indices
//   keep_mask : low-order run of ones, one per valid lane (up to MAX_RATIO lanes)
package stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MAX_RATIO = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // n_lanes ones starting at bit 0; one extra bit so n_lanes == MAX_RATIO works.
    function automatic logic [MAX_RATIO-1:0] keep_mask(input int n_lanes);
        logic [MAX_RATIO:0] m;
        m = ((MAX_RATIO + 1)'(1) << n_lanes) - (MAX_RATIO + 1)'(1);
        return m[MAX_RATIO-1:0];
    endfunction

endpackage

// File: rtl/frame_counter.sv
// frame_counter: words-remaining down-counter for one frame.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over dec)
//   load_val   : frame length in words
//   dec        : decrement by one
//   is_one     : count currently equals 1 (the next word ends the frame)
module frame_counter
    import stream_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - CNT_W'(1);
        end
    end

    assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/stream_pack.sv
// stream_pack: packs RATIO narrow words from a first-word-fall-through FIFO
// into one wide AXI-Stream beat, lane 0 first, with per-frame tlast and a
// zero-filled, keep-masked short final beat.
//   clk, reset   : clock, synchronous active-high reset
//   in_empty_n   : upstream FIFO holds a word; in_data valid while high
//   in_data      : head word of the upstream FIFO
//   in_deq       : pop the head word at this edge (combinational)
//   frame_words  : words per frame, sampled only while idle
//   m_tdata      : packed beat, lane k at [k*IN_W +: IN_W]
//   m_tkeep      : one bit per valid lane
//   m_tvalid     : beat valid
//   m_tready     : downstream accepts the beat
//   m_tlast      : final beat of the frame
//   busy         : frame in progress or a beat still waiting
module stream_pack
    import stream_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int RATIO = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_empty_n,
    input  logic [IN_W-1:0]       in_data,
    output logic                  in_deq,
    input  logic [CNT_W-1:0]      frame_words,
    output logic [IN_W*RATIO-1:0] m_tdata,
    output logic [RATIO-1:0]      m_tkeep,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy
);

    localparam int                LANE_W    = clog2(RATIO);
    localparam int                OUT_W     = IN_W * RATIO;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    state_t            state, state_next;
    logic [LANE_W-1:0] lane, lane_next;
    logic [IN_W-1:0]   acc [RATIO-1];
    logic              rem_is_one;
    logic              completing;
    logic              out_free;
    logic              start;
    logic              load_beat;
    logic [OUT_W-1:0]  beat_data;
    logic [RATIO-1:0]  beat_keep;

    frame_counter #(
        .CNT_W(CNT_W)
    ) u_frame_counter (
        .clk     (clk),
        .reset   (reset),
        .load    (start),
        .load_val(frame_words),
        .dec     (in_deq),
        .is_one  (rem_is_one)
    );

    // A word completes a beat if it fills the top lane or ends the frame.
    assign completing = (lane == LAST_LANE) || rem_is_one;
    assign out_free   = !m_tvalid || m_tready;
    assign load_beat  = in_deq && completing;

    always_comb begin
        state_next = state;
        lane_next  = lane;
        start      = 1'b0;
        in_deq     = 1'b0;
        case (state)
            IDLE: begin
                if (frame_words != '0) begin
                    start      = 1'b1;
                    lane_next  = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                // Filling the accumulator never waits on the output; only the
                // word that completes a beat needs the output register free.
                in_deq = in_empty_n && (completing ? out_free : 1'b1);
                if (in_deq) begin
                    lane_next = completing ? '0 : lane + LANE_W'(1);
                    if (rem_is_one) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            in_deq = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            lane  <= '0;
        end else begin
            state <= state_next;
            lane  <= lane_next;
        end
    end

    // ---- stage 0: accumulate non-completing words ----
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < RATIO - 1; k++) begin
                acc[k] <= '0;
            end
        end else if (in_deq && !completing) begin
            for (int k = 0; k < RATIO - 1; k++) begin
                if (lane == LANE_W'(k)) begin
                    acc[k] <= in_data;
                end
            end
        end
    end

    // Beat = accumulated lanes below `lane`, the incoming word at `lane`,
    // zeros above.
    always_comb begin
        beat_data = '0;
        for (int k = 0; k < RATIO - 1; k++) begin
            if (LANE_W'(k) < lane) begin
                beat_data[k*IN_W +: IN_W] = acc[k];
            end
        end
        for (int k = 0; k < RATIO; k++) begin
            if (LANE_W'(k) == lane) begin
                beat_data[k*IN_W +: IN_W] = in_data;
            end
        end
        beat_keep = RATIO'(keep_mask(32'(lane) + 1));
    end

    // ---- stage 1: output beat register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tvalid <= 1'b0;
        end else if (load_beat) begin
            m_tdata  <= beat_data;
            m_tkeep  <= beat_keep;
            m_tlast  <= rem_is_one;
            m_tvalid <= 1'b1;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    assign busy = (state == RUN) || m_tvalid;

endmodule

// File: tb/tb_stream_pack.sv
module tb_stream_pack;

    localparam int IN_W  = 8;
    localparam int RATIO = 4;
    localparam int CNT_W = 16;
    localparam int OUT_W = IN_W * RATIO;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_empty_n;
    logic [IN_W-1:0]  in_data;
    logic             in_deq;
    logic [CNT_W-1:0] frame_words;
    logic [OUT_W-1:0] m_tdata;
    logic [RATIO-1:0] m_tkeep;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic             busy;

    stream_pack #(.IN_W(IN_W), .RATIO(RATIO), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_empty_n (in_empty_n),
        .in_data    (in_data),
        .in_deq     (in_deq),
        .frame_words(frame_words),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [RATIO-1:0] keep;
        logic             last;
    } beat_t;

    typedef struct {
        int               fw;
        int               base;
        int               avail;
        int               nbeats;
        logic [OUT_W-1:0] d0;
        logic [RATIO-1:0] k0;
        logic             l0;
        logic [OUT_W-1:0] d1;
        logic [RATIO-1:0] k1;
        logic             l1;
    } vec_t;

    int n_checks = 0;
    int n_fails  = 0;

    logic [IN_W-1:0] words[$];
    logic [IN_W-1:0] src[$];
    logic [IN_W-1:0] consumed[$];
    beat_t           got[$];
    beat_t           exp_q[$];

    int    cyc = 0;
    int    avail_mode = 0;   // 0 always, 1 toggle, 2 random
    int    ready_mode = 0;   // 0 high, 1 low, 2 random
    int    cur_fw = 0;
    int    frame_t = 0;
    int    first_deq = -1;
    int    last_deq = -1;
    int    last_accept_cyc = 0;
    logic  s_deq = 1'b0;
    logic  s_busy = 1'b0;
    logic  s_empty_n = 1'b0;
    logic  p_hold = 1'b0;
    beat_t p_beat = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive();
        logic a;
        case (avail_mode)
            1:       a = ((cyc % 2) == 0);
            2:       a = ($urandom_range(0, 3) != 0);
            default: a = 1'b1;
        endcase
        in_empty_n = a && (src.size() > 0);
        in_data    = in_empty_n ? src[0] : IN_W'($urandom);
        case (ready_mode)
            1:       m_tready = 1'b0;
            2:       m_tready = ($urandom_range(0, 2) != 0);
            default: m_tready = 1'b1;
        endcase
    endtask

    // One clock: sample at the falling edge, advance the FIFO model after the
    // rising edge, then drive new inputs.
    task automatic tick();
        @(negedge clk);
        s_deq     = in_deq;
        s_busy    = busy;
        s_empty_n = in_empty_n;
        if (!reset) begin
            if (in_deq) begin
                chk("deq_needs_word", in_empty_n, 1);
                consumed.push_back(in_data);
                if (first_deq < 0) first_deq = frame_t;
                last_deq = frame_t;
            end
            if (p_hold) begin
                chk("hold_valid", m_tvalid, 1);
                chk("hold_beat", {m_tdata, m_tkeep, m_tlast}, p_beat);
            end
            if (m_tvalid && m_tready) begin
                got.push_back({m_tdata, m_tkeep, m_tlast});
                last_accept_cyc = cyc;
            end
            p_hold = m_tvalid && !m_tready;
            p_beat = {m_tdata, m_tkeep, m_tlast};
        end else begin
            p_hold = 1'b0;
        end
        frame_t++;
        @(posedge clk);
        #1;
        cyc++;
        if (s_deq && src.size() > 0) void'(src.pop_front());
        drive();
    endtask

    // Reference: chop the frame into RATIO-word groups, last group short.
    task automatic build_expected(input int fw);
        exp_q.delete();
        for (int i = 0; i < fw; i += RATIO) begin
            int    n;
            beat_t b;
            n = (fw - i < RATIO) ? fw - i : RATIO;
            b = '0;
            for (int j = 0; j < n; j++) b.data[j*IN_W +: IN_W] = words[i + j];
            b.keep = RATIO'((1 << n) - 1);
            b.last = (i + RATIO >= fw);
            exp_q.push_back(b);
        end
    endtask

    task automatic start_frame(input int fw);
        consumed.delete();
        got.delete();
        src = words;
        cur_fw = fw;
        build_expected(fw);
        frame_words = CNT_W'(fw);
        drive();
        frame_t = 0;
        first_deq = -1;
        last_deq = -1;
        tick();
        frame_words = '0;
    endtask

    task automatic finish_frame(input string tag);
        int t;
        t = 0;
        while (!(got.size() >= exp_q.size() && !s_busy) && t < 400) begin
            tick();
            t++;
        end
        chk($sformatf("%s_done_in_time", tag), (t < 400), 1);
        chk($sformatf("%s_busy_fall", tag), (cyc - 1) - last_accept_cyc, 1);
        chk($sformatf("%s_beat_count", tag), got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s_beat%0d_data", tag, i), got[i].data, exp_q[i].data);
            chk($sformatf("%s_beat%0d_keep", tag, i), got[i].keep, exp_q[i].keep);
            chk($sformatf("%s_beat%0d_last", tag, i), got[i].last, exp_q[i].last);
        end
        chk($sformatf("%s_word_count", tag), consumed.size(), cur_fw);
        for (int i = 0; i < cur_fw && i < consumed.size(); i++) begin
            chk($sformatf("%s_word%0d", tag, i), consumed[i], words[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int   n;

        vecs[0] = '{8, 8'h01, 0, 2, 32'h04030201, 4'hF, 1'b0, 32'h08070605, 4'hF, 1'b1};
        vecs[1] = '{6, 8'h01, 0, 2, 32'h04030201, 4'hF, 1'b0, 32'h00000605, 4'h3, 1'b1};
        vecs[2] = '{8, 8'h01, 1, 2, 32'h04030201, 4'hF, 1'b0, 32'h08070605, 4'hF, 1'b1};
        vecs[3] = '{1, 8'h55, 0, 1, 32'h00000055, 4'h1, 1'b1, 32'h0, 4'h0, 1'b0};
        vecs[4] = '{4, 8'h10, 0, 1, 32'h13121110, 4'hF, 1'b1, 32'h0, 4'h0, 1'b0};
        vecs[5] = '{5, 8'h21, 0, 2, 32'h24232221, 4'hF, 1'b0, 32'h00000025, 4'h1, 1'b1};
        vecs[6] = '{7, 8'hF0, 1, 2, 32'hF3F2F1F0, 4'hF, 1'b0, 32'h00F6F5F4, 4'h7, 1'b1};

        reset = 1'b1;
        frame_words = '0;
        drive();
        tick();
        tick();
        chk("reset_tvalid", m_tvalid, 0);
        chk("reset_tdata", m_tdata, 0);
        chk("reset_tkeep", m_tkeep, 0);
        chk("reset_tlast", m_tlast, 0);
        chk("reset_busy", busy, 0);
        chk("reset_deq", in_deq, 0);
        reset = 1'b0;
        tick();

        // Zero-length frame request: nothing moves.
        words = '{8'h55};
        src = words;
        frame_words = '0;
        drive();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fw0_no_deq", s_deq, 0);
            chk("fw0_not_busy", s_busy, 0);
        end

        // Table-driven frames.
        for (int v = 0; v < 7; v++) begin
            words.delete();
            for (int i = 0; i < vecs[v].fw; i++) words.push_back(IN_W'(vecs[v].base + i));
            avail_mode = vecs[v].avail;
            ready_mode = 0;
            start_frame(vecs[v].fw);
            finish_frame($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_nbeats", v), got.size(), vecs[v].nbeats);
            if (got.size() > 0) begin
                chk($sformatf("vec%0d_d0", v), got[0].data, vecs[v].d0);
                chk($sformatf("vec%0d_k0", v), got[0].keep, vecs[v].k0);
                chk($sformatf("vec%0d_l0", v), got[0].last, vecs[v].l0);
            end
            if (vecs[v].nbeats > 1 && got.size() > 1) begin
                chk($sformatf("vec%0d_d1", v), got[1].data, vecs[v].d1);
                chk($sformatf("vec%0d_k1", v), got[1].keep, vecs[v].k1);
                chk($sformatf("vec%0d_l1", v), got[1].last, vecs[v].l1);
            end
            if (vecs[v].avail == 0) begin
                chk($sformatf("vec%0d_first_deq", v), first_deq, 1);
                chk($sformatf("vec%0d_last_deq", v), last_deq, vecs[v].fw);
            end
        end

        // Backpressure: first beat waits 5 cycles, completing word stalls.
        words.delete();
        for (int i = 1; i <= 8; i++) words.push_back(IN_W'(i));
        avail_mode = 0;
        ready_mode = 1;
        start_frame(8);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n += int'(s_deq);
        end
        chk("bp_first_words", n, 4);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n += int'(s_deq);
        end
        chk("bp_words_during_stall", n, 3);
        chk("bp_stall_deq", s_deq, 0);
        chk("bp_stall_word_ready", s_empty_n, 1);
        chk("bp_held_data", m_tdata, 32'h04030201);
        chk("bp_held_valid", m_tvalid, 1);
        ready_mode = 0;
        drive();
        finish_frame("bp");

        // Reset in the middle of a frame with a beat waiting and lanes filled.
        words.delete();
        for (int i = 1; i <= 8; i++) words.push_back(IN_W'(i));
        ready_mode = 1;
        start_frame(8);
        for (int i = 0; i < 7; i++) tick();
        chk("rst_pre_valid", m_tvalid, 1);
        reset = 1'b1;
        drive();
        tick();
        chk("rst_deq_forced_low", s_deq, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tkeep", m_tkeep, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        ready_mode = 0;
        drive();
        tick();
        chk("rst_idle_deq", s_deq, 0);
        chk("rst_idle_busy", s_busy, 0);
        words = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        start_frame(4);
        finish_frame("rst_new");
        if (got.size() > 0) begin
            chk("rst_new_data", got[0].data, 32'h0D0C0B0A);
            chk("rst_new_keep", got[0].keep, 4'hF);
            chk("rst_new_last", got[0].last, 1);
        end

        // Randomized frames against the reference.
        for (int f = 0; f < 25; f++) begin
            int fw;
            fw = $urandom_range(1, 13);
            words.delete();
            for (int i = 0; i < fw; i++) words.push_back(IN_W'($urandom));
            avail_mode = $urandom_range(0, 2);
            ready_mode = 2;
            start_frame(fw);
            finish_frame($sformatf("rand%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
